// File: rtl/display_scan_if.sv
// Control/data bundle between the converter datapath and the display scan controller.
// master drives the value and strobes; slave drives the board-facing outputs.
interface display_scan_if;
  logic        enable;
  logic        load;
  logic [15:0] valor;
  logic        lz_suppress;
  logic [3:0]  anodo;
  logic [6:0]  seg;
  logic [1:0]  digit_sel;
  logic        frame_tick;
  logic        pend;

  modport master (
    output enable, load, valor, lz_suppress,
    input  anodo, seg, digit_sel, frame_tick, pend
  );

  modport slave (
    input  enable, load, valor, lz_suppress,
    output anodo, seg, digit_sel, frame_tick, pend
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode 7-segment scan scheduler with per-slot blanking guard and
// frame-synchronous value update so a frame never mixes old and new digits.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic          clk,
  input logic          rst_n,
  display_scan_if.slave bus
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] SlotLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [15:0]     shown_q, shown_d;
  logic [15:0]     pending_q, pending_d;
  logic            pend_q, pend_d;
  logic [3:0]      anodo_q, anodo_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      digit_sel_q;
  logic            frame_tick_q;
  logic            frame_start;
  logic [3:0]      nib;
  logic [3:0]      zero_above;
  logic            suppress;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    frame_start = 1'b0;
    if (!bus.enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d     = StBlank;
          cnt_d       = '0;
          digit_d     = '0;
          frame_start = 1'b1;
        end
        StBlank: begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == BlankLast) state_d = StOn;
        end
        StOn: begin
          if (cnt_q == SlotLast) begin
            state_d     = StBlank;
            cnt_d       = '0;
            digit_d     = digit_q + 2'd1;
            frame_start = (digit_q == 2'd3);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A load on the frame-start edge bypasses the pending register so the newest value wins.
  always_comb begin
    pending_d = pending_q;
    pend_d    = pend_q;
    shown_d   = shown_q;
    if (bus.load) begin
      pending_d = bus.valor;
      pend_d    = 1'b1;
    end
    if (frame_start) begin
      if (bus.load) begin
        shown_d = bus.valor;
      end else if (pend_q) begin
        shown_d = pending_q;
      end
      pend_d = 1'b0;
    end
  end

  // zero_above[d]: nibble d and every higher nibble are zero; digit 0 is never blanked.
  always_comb begin
    zero_above[3] = (shown_d[15:12] == 4'h0);
    zero_above[2] = zero_above[3] && (shown_d[11:8] == 4'h0);
    zero_above[1] = zero_above[2] && (shown_d[7:4] == 4'h0);
    zero_above[0] = 1'b0;
    nib           = shown_d[{digit_d, 2'b00} +: 4];
    suppress      = bus.lz_suppress && zero_above[digit_d];
    anodo_d       = 4'hF;
    seg_d         = 7'h7F;
    if (state_d == StOn) begin
      anodo_d = ~(4'b0001 << digit_d);
      if (!suppress) seg_d = decode(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      digit_q      <= '0;
      shown_q      <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      anodo_q      <= 4'hF;
      seg_q        <= 7'h7F;
      digit_sel_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shown_q      <= shown_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      anodo_q      <= anodo_d;
      seg_q        <= seg_d;
      digit_sel_q  <= digit_d;
      frame_tick_q <= frame_start;
    end
  end

  assign bus.anodo      = anodo_q;
  assign bus.seg        = seg_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.pend       = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: expected per-cycle outputs are queued from a small
// reference model as stimulus is planned, then popped and compared every clock.
module tb_display_scan_ctrl;

  localparam int unsigned RD = 8;
  localparam int unsigned BL = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic [1:0] ds;
    logic       ft;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  exp_t sb[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_if bus ();

  display_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(input logic [15:0] v, input int d, input logic lz);
    logic [3:0] nib;
    bit         all_zero;
    nib = v[4*d +: 4];
    if (lz && d > 0) begin
      all_zero = 1'b1;
      for (int k = d; k < 4; k++) if (v[4*k +: 4] != 4'h0) all_zero = 1'b0;
      if (all_zero) return 7'h7F;
    end
    return seg_tab[nib];
  endfunction

  // Queue the first n cycles of a frame showing v.
  task automatic push_frame(input logic [15:0] v, input logic lz, input int n);
    exp_t       e;
    logic [3:0] one;
    int         d;
    int         c;
    one = 4'b0001;
    for (int i = 0; i < n; i++) begin
      d    = i / RD;
      c    = i % RD;
      e.an = (c < BL) ? 4'hF : ~(one << d);
      e.sg = (c < BL) ? 7'h7F : model_seg(v, d, lz);
      e.ds = 2'(d);
      e.ft = (i == 0);
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = {4'hF, 7'h7F, 2'd0, 1'b0};
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $error("FAIL scoreboard_empty cycle %0d: no expected entry queued", cyc);
      end else begin
        e   = sb.pop_front();
        got = {bus.anodo, bus.seg, bus.digit_sel, bus.frame_tick};
        assert (got === e) else begin
          failures++;
          $error("FAIL scan cycle %0d: got an=%b seg=%h dsel=%0d ft=%b, want an=%b seg=%h dsel=%0d ft=%b",
                 cyc, got.an, got.sg, got.ds, got.ft, e.an, e.sg, e.ds, e.ft);
        end
      end
    end
  endtask

  task automatic check_pend(input string tag, input logic want);
    checks++;
    assert (bus.pend === want) else begin
      failures++;
      $error("FAIL %s: pend got %b want %b", tag, bus.pend, want);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.load        = 1'b0;
    bus.valor       = 16'h0000;
    bus.lz_suppress = 1'b0;

    // Reset state
    push_idle(3);
    run(3);
    check_pend("reset_pend", 1'b0);

    // Frame 1 shows 0000 while 1234 is loaded; frame 2 shows 1234
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    push_frame(16'h0000, 1'b0, 32);
    push_frame(16'h1234, 1'b0, 32);
    run(1);
    bus.load  = 1'b1;
    bus.valor = 16'h1234;
    run(1);
    bus.load = 1'b0;
    check_pend("pend_after_load", 1'b1);
    run(30);
    check_pend("pend_held_frame1", 1'b1);
    run(1);
    check_pend("pend_cleared_frame2", 1'b0);
    run(31);

    // No tearing: ABCD loaded during digit 2 ON phase
    push_frame(16'h1234, 1'b0, 32);
    push_frame(16'hABCD, 1'b0, 32);
    run(19);
    bus.load  = 1'b1;
    bus.valor = 16'hABCD;
    run(1);
    bus.load = 1'b0;
    check_pend("pend_tear_load", 1'b1);
    run(12);
    check_pend("pend_tear_held", 1'b1);
    run(1);
    check_pend("pend_tear_cleared", 1'b0);
    run(31);

    // Leading-zero suppression: 0070 then 0000, then 1111 pending
    bus.lz_suppress = 1'b1;
    push_frame(16'hABCD, 1'b1, 32);
    push_frame(16'h0070, 1'b1, 32);
    push_frame(16'h0000, 1'b1, 32);
    run(5);
    bus.load  = 1'b1;
    bus.valor = 16'h0070;
    run(1);
    bus.load = 1'b0;
    run(26);
    run(10);
    bus.load  = 1'b1;
    bus.valor = 16'h0000;
    run(1);
    bus.load = 1'b0;
    run(21);
    run(10);
    bus.load  = 1'b1;
    bus.valor = 16'h1111;
    run(1);
    bus.load = 1'b0;
    run(21);
    check_pend("pend_1111_waiting", 1'b1);

    // Simultaneous: load 2222 on the frame-start edge overrides pending 1111
    push_frame(16'h2222, 1'b1, 32);
    bus.load  = 1'b1;
    bus.valor = 16'h2222;
    run(1);
    bus.load = 1'b0;
    check_pend("pend_same_edge", 1'b0);
    run(31);

    // Enable drop mid-ON on digit 2, then restart at digit 0
    push_frame(16'h2222, 1'b1, 21);
    run(21);
    bus.enable = 1'b0;
    push_idle(3);
    run(3);
    check_pend("pend_enable_low", 1'b0);
    bus.enable = 1'b1;
    push_frame(16'h2222, 1'b1, 32);
    run(32);

    // Reset mid-ON with a pending value; load during reset is ignored
    push_frame(16'h2222, 1'b1, 13);
    run(12);
    bus.load  = 1'b1;
    bus.valor = 16'h5555;
    run(1);
    bus.load = 1'b0;
    check_pend("pend_before_reset", 1'b1);
    rst_n           = 1'b0;
    bus.lz_suppress = 1'b0;
    bus.load        = 1'b1;
    bus.valor       = 16'h9999;
    push_idle(3);
    run(1);
    bus.load = 1'b0;
    run(2);
    check_pend("pend_in_reset", 1'b0);
    rst_n = 1'b1;
    push_frame(16'h0000, 1'b0, 32);
    run(1);
    check_pend("pend_after_reset", 1'b0);
    run(31);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
